mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter between the pipeline's instruction and data buses and a single unified memory port. It sits directly downstream of the pipeline. It serialises fetch and load/store requests onto one request/acknowledge bus, and handles byte-lane steering, byte enables and read-data alignment for sub-doubleword accesses. It returns single-cycle completion pulses to the pipeline.

---
 rtl/raisin64_mem_pkg.sv | 27 ++
 rtl/mem_lane.sv | 32 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raisin64_mem_pkg.sv
// Shared memory-access definitions: access width encodings and arbiter FSM states.
// Also used by ex_memory.
package raisin64_mem_pkg;

  localparam logic [1:0] W_BYTE  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_WORD  = 2'b10;
  localparam logic [1:0] W_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS_I = 2'b01,
    BUS_D = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

  // Byte offset within the doubleword; misaligned low bits are dropped.
  function automatic logic [2:0] lane_off(input logic [1:0] width, input logic [2:0] addr_lo);
    case (width)
      W_BYTE:  return addr_lo;
      W_HALF:  return {addr_lo[2:1], 1'b0};
      W_WORD:  return {addr_lo[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for sub-doubleword accesses: byte enables, store-data
// placement and load-data right-alignment with zero extension.
module mem_lane
  import raisin64_mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata_in,
  input  logic [63:0] rdata_in,
  output logic [2:0]  off,
  output logic [7:0]  be,
  output logic [63:0] wdata_out,
  output logic [63:0] rdata_out
);

  logic [7:0]  base_be;
  logic [63:0] rmask;

  always_comb begin
    off = lane_off(width, addr_lo);
    case (width)
      W_BYTE:  begin base_be = 8'h01; rmask = 64'h0000_0000_0000_00FF; end
      W_HALF:  begin base_be = 8'h03; rmask = 64'h0000_0000_0000_FFFF; end
      W_WORD:  begin base_be = 8'h0F; rmask = 64'h0000_0000_FFFF_FFFF; end
      default: begin base_be = 8'hFF; rmask = '1; end
    endcase
    be        = base_be << off;
    wdata_out = wdata_in << {off, 3'b000};
    rdata_out = (rdata_in >> {off, 3'b000}) & rmask;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one req/ack memory port,
// with registered bus fields and single-cycle completion pulses.
module mem_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] imem_addr,
  input  logic        imem_addr_valid,
  output logic [63:0] imem_data,
  output logic        imem_data_valid,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_write_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  arb_state_t  state, state_next;
  logic [63:0] lat_addr;
  logic [1:0]  lat_width;
  logic [2:0]  lat_off;
  logic        last_d;
  logic        resp_d;
  logic        i_pend, d_pend, fetch_fresh;
  logic [1:0]  lane_width;
  logic [2:0]  lane_addr;
  logic [2:0]  lane_off_q;
  logic [7:0]  lane_be;
  logic [63:0] lane_wdata, lane_rdata;

  // One lane unit: steers the incoming request in IDLE, aligns read data in BUS_D.
  always_comb begin
    lane_width = (state == IDLE) ? dmem_write_width : lat_width;
    lane_addr  = (state == IDLE) ? dmem_addr[2:0]   : lat_off;
  end

  mem_lane u_lane (
    .width     (lane_width),
    .addr_lo   (lane_addr),
    .wdata_in  (dmem_dout),
    .rdata_in  (mem_rdata),
    .off       (lane_off_q),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  always_comb begin
    i_pend      = imem_addr_valid;
    d_pend      = dmem_rstrobe | dmem_wstrobe;
    fetch_fresh = imem_addr_valid && (imem_addr == lat_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_pend && i_pend) state_next = (FAIR && last_d) ? BUS_I : BUS_D;
        else if (d_pend)      state_next = BUS_D;
        else if (i_pend)      state_next = BUS_I;
      end
      BUS_I: if (mem_ack) state_next = fetch_fresh ? RESP : IDLE;
      BUS_D: if (mem_ack) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req             = (state == BUS_I) || (state == BUS_D);
    imem_data_valid     = (state == RESP) && !resp_d;
    dmem_cycle_complete = (state == RESP) && resp_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      lat_addr  <= '0;
      lat_width <= '0;
      lat_off   <= '0;
      last_d    <= 1'b0;
      resp_d    <= 1'b0;
      imem_data <= '0;
      dmem_din  <= '0;
    end else begin
      if (state == IDLE && state_next == BUS_I) begin
        mem_addr  <= {imem_addr[63:3], 3'b000};
        mem_wdata <= '0;
        mem_be    <= '1;
        mem_we    <= 1'b0;
        lat_addr  <= imem_addr;
        last_d    <= 1'b0;
        resp_d    <= 1'b0;
      end
      if (state == IDLE && state_next == BUS_D) begin
        mem_addr  <= {dmem_addr[63:3], 3'b000};
        mem_wdata <= lane_wdata;
        mem_be    <= lane_be;
        mem_we    <= dmem_wstrobe;
        lat_width <= dmem_write_width;
        lat_off   <= lane_off_q;
        last_d    <= 1'b1;
        resp_d    <= 1'b1;
      end
      if (state == BUS_I && mem_ack && fetch_fresh) imem_data <= mem_rdata;
      // Stores (including rstrobe+wstrobe together) leave load data untouched.
      if (state == BUS_D && mem_ack && !mem_we)     dmem_din  <= lane_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a byte-level memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr, dmem_addr, dmem_dout, mem_rdata;
  logic        imem_addr_valid, dmem_rstrobe, dmem_wstrobe, mem_ack;
  logic [1:0]  dmem_write_width;
  logic [63:0] imem_data, dmem_din, mem_addr, mem_wdata;
  logic        imem_data_valid, dmem_cycle_complete, mem_we, mem_req;
  logic [7:0]  mem_be;

  logic [63:0] d0_imem_data, d0_dmem_din, d0_addr, d0_wdata;
  logic        d0_iv, d0_cc, d0_we, d0_req, d0_ack;
  logic [7:0]  d0_be;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_write_width(dmem_write_width),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_din(dmem_din), .dmem_cycle_complete(dmem_cycle_complete),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Second instance with data-always-wins ties; its memory acks immediately.
  assign d0_ack = d0_req;
  mem_arbiter #(.FAIR(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(d0_imem_data), .imem_data_valid(d0_iv),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_write_width(dmem_write_width),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_din(d0_dmem_din), .dmem_cycle_complete(d0_cc),
    .mem_addr(d0_addr), .mem_wdata(d0_wdata), .mem_be(d0_be), .mem_we(d0_we),
    .mem_req(d0_req), .mem_rdata(mem_rdata), .mem_ack(d0_ack)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
  } bus_t;

  bus_t        log_q[$];
  logic [63:0] mem_m [logic [63:0]];
  int unsigned ws;
  int          total, bad;
  logic [63:0] exp_din;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_read(input logic [63:0] da);
    if (mem_m.exists(da)) return mem_m[da];
    return {da[31:0] ^ 32'h5A5A_C3C3, ~da[31:0] + 32'h0000_1357};
  endfunction

  function automatic int unsigned off_of(input logic [1:0] w, input logic [63:0] a);
    int unsigned n = 1 << w;
    return (int'(a[2:0]) / n) * n;
  endfunction

  function automatic logic [7:0] model_be(input logic [1:0] w, input logic [63:0] a);
    int unsigned n = 1 << w;
    int unsigned o = off_of(w, a);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = (i >= o) && (i < o + n);
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [1:0] w, input logic [63:0] a,
                                              input logic [63:0] d);
    int unsigned o = off_of(w, a);
    logic [63:0] r = '0;
    for (int unsigned l = o; l < 8; l++) r[8*l +: 8] = d[8*(l-o) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_din(input logic [1:0] w, input logic [63:0] a,
                                            input logic [63:0] rd);
    int unsigned n = 1 << w;
    int unsigned o = off_of(w, a);
    logic [63:0] r = '0;
    for (int unsigned i = 0; i < n; i++) r[8*i +: 8] = rd[8*(o+i) +: 8];
    return r;
  endfunction

  // Memory responder: acks after ws waiting cycles, applies stores to the model.
  logic [63:0] snap_addr, snap_wdata;
  logic [8:0]  snap_ctl;
  int unsigned r_cnt;
  logic        r_act;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      r_cnt   = 0;
      r_act   = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (!r_act) begin
        r_act      = 1'b1;
        r_cnt      = 0;
        snap_addr  = mem_addr;
        snap_wdata = mem_wdata;
        snap_ctl   = {mem_we, mem_be};
      end
      if (r_cnt == ws) begin
        if (r_cnt != 0) begin
          check("stable_addr", mem_addr, snap_addr);
          check("stable_ctl", {55'd0, mem_we, mem_be}, {55'd0, snap_ctl});
          check("stable_wdata", mem_wdata, snap_wdata);
        end
        mem_rdata = mem_read(mem_addr);
        if (mem_we) begin
          logic [63:0] t;
          t = mem_read(mem_addr);
          for (int i = 0; i < 8; i++) if (mem_be[i]) t[8*i +: 8] = mem_wdata[8*i +: 8];
          mem_m[mem_addr] = t;
        end
        log_q.push_back('{mem_addr, mem_be, mem_we, mem_wdata});
        mem_ack = 1'b1;
        r_act   = 1'b0;
      end else begin
        r_cnt++;
      end
    end
  end

  task automatic do_fetch(input logic [63:0] a, input string tag);
    int unsigned cyc = 0;
    logic seen = 1'b0;
    log_q.delete();
    imem_addr = a;
    imem_addr_valid = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (imem_data_valid) seen = 1'b1;
    end
    imem_addr_valid = 1'b0;
    check({tag, "_done"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      check({tag, "_lat"}, cyc, ws + 2);
      check({tag, "_data"}, imem_data, mem_read({a[63:3], 3'b000}));
      check({tag, "_nbus"}, log_q.size(), 1);
      if (log_q.size() > 0) begin
        check({tag, "_addr"}, log_q[0].addr, {a[63:3], 3'b000});
        check({tag, "_be"}, {55'd0, log_q[0].we, log_q[0].be}, {55'd0, 1'b0, 8'hFF});
      end
      @(negedge clk);
      check({tag, "_pulse1"}, {63'd0, imem_data_valid}, 64'd0);
    end
  endtask

  task automatic do_data(input logic [63:0] a, input logic [1:0] w, input logic [63:0] d,
                         input logic rd, input logic wr, input string tag);
    int unsigned cyc = 0;
    logic seen = 1'b0;
    log_q.delete();
    dmem_addr = a;
    dmem_write_width = w;
    dmem_dout = d;
    dmem_rstrobe = rd;
    dmem_wstrobe = wr;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dmem_cycle_complete) seen = 1'b1;
    end
    dmem_rstrobe = 1'b0;
    dmem_wstrobe = 1'b0;
    check({tag, "_done"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      check({tag, "_lat"}, cyc, ws + 2);
      check({tag, "_nbus"}, log_q.size(), 1);
      if (log_q.size() > 0) begin
        check({tag, "_addr"}, log_q[0].addr, {a[63:3], 3'b000});
        check({tag, "_be"}, {56'd0, log_q[0].be}, {56'd0, model_be(w, a)});
        check({tag, "_we"}, {63'd0, log_q[0].we}, {63'd0, wr});
        if (wr) check({tag, "_wdata"}, log_q[0].wdata, model_wdata(w, a, d));
      end
      if (!wr) exp_din = model_din(w, a, mem_read({a[63:3], 3'b000}));
      check({tag, "_din"}, dmem_din, exp_din);
      @(negedge clk);
      check({tag, "_pulse1"}, {63'd0, dmem_cycle_complete}, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0, quiet;
    rst_n = 1'b1;
    imem_addr = '0; imem_addr_valid = 1'b0;
    dmem_addr = '0; dmem_dout = '0; dmem_write_width = '0;
    dmem_rstrobe = 1'b0; dmem_wstrobe = 1'b0;
    mem_rdata = '0;
    ws = 0; total = 0; bad = 0; exp_din = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", {63'd0, mem_req}, 64'd0);
    check("rst_ctl", {53'd0, mem_be, mem_we, imem_data_valid, dmem_cycle_complete}, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_din", dmem_din, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mem_m[64'h1000] = 64'h1122_3344_5566_7788;
    do_fetch(64'h1000, "fetch1000");
    check("fetch1000_val", imem_data, 64'h1122_3344_5566_7788);

    do_data(64'h2005, 2'b00, 64'hAB, 1'b0, 1'b1, "sb2005");
    if (log_q.size() > 0) begin
      check("sb2005_be20", {56'd0, log_q[0].be}, 64'h20);
      check("sb2005_lane", {56'd0, log_q[0].wdata[47:40]}, 64'hAB);
    end

    mem_m[64'h3000] = 64'hBEEF_0000_0000_0000;
    do_data(64'h3006, 2'b01, 64'd0, 1'b1, 1'b0, "lh3006");
    check("lh3006_val", dmem_din, 64'h0000_0000_0000_BEEF);
    do_data(64'h3007, 2'b01, 64'd0, 1'b1, 1'b0, "lh3007");
    check("lh3007_val", dmem_din, 64'h0000_0000_0000_BEEF);

    do_data(64'h3010, 2'b10, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, "rw_both");
    check("rw_both_hold", dmem_din, 64'h0000_0000_0000_BEEF);

    // Fetch redirected before its ack: stale data dropped, refetch follows.
    ws = 3;
    log_q.delete();
    imem_addr = 64'h100;
    imem_addr_valid = 1'b1;
    repeat (2) @(negedge clk);
    imem_addr = 64'h200;
    begin
      int unsigned cyc = 0;
      logic seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (imem_data_valid) seen = 1'b1;
      end
      imem_addr_valid = 1'b0;
      check("stale_done", {63'd0, seen}, 64'd1);
      check("stale_nbus", log_q.size(), 2);
      if (log_q.size() >= 2) begin
        check("stale_a0", log_q[0].addr, 64'h100);
        check("stale_a1", log_q[1].addr, 64'h200);
      end
      check("stale_data", imem_data, mem_read(64'h200));
      @(negedge clk);
    end
    ws = 0;

    // Both masters pending continuously from reset (last grant = instruction).
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_din = '0;
    log_q.delete();
    imem_addr = 64'h4000; imem_addr_valid = 1'b1;
    dmem_addr = 64'h5008; dmem_write_width = 2'b11; dmem_dout = 64'h0F0E_0D0C_0B0A_0908;
    dmem_wstrobe = 1'b1;
    n0 = 0;
    repeat (15) begin
      @(negedge clk);
      if (d0_req) begin
        n0++;
        check("fair0_grant_d", {63'd0, d0_we}, 64'd1);
      end
    end
    imem_addr_valid = 1'b0;
    dmem_wstrobe = 1'b0;
    repeat (4) @(negedge clk);
    check("fair0_cnt", {63'd0, n0 >= 3}, 64'd1);
    check("fair_cnt", {63'd0, log_q.size() >= 4}, 64'd1);
    if (log_q.size() >= 4)
      for (int i = 0; i < 4; i++)
        check("fair_order", {63'd0, log_q[i].we}, {63'd0, (i % 2) == 0});

    // Reset while a store waits on a slow memory.
    ws = 3;
    log_q.delete();
    dmem_addr = 64'h6000; dmem_write_width = 2'b11; dmem_dout = 64'hCAFE_F00D_DEAD_BEEF;
    dmem_wstrobe = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_pre_req", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", {63'd0, mem_req}, 64'd0);
    check("midrst_ctl", {53'd0, mem_be, mem_we, imem_data_valid, dmem_cycle_complete}, 64'd0);
    check("midrst_addr", mem_addr, 64'd0);
    check("midrst_wdata", mem_wdata, 64'd0);
    check("midrst_idata", imem_data, 64'd0);
    dmem_wstrobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_din = '0;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      quiet += imem_data_valid + dmem_cycle_complete + mem_req;
    end
    check("midrst_quiet", quiet, 0);
    check("midrst_noack", log_q.size(), 0);
    ws = 0;
    do_fetch(64'h7000, "post_rst_fetch");

    for (int it = 0; it < 40; it++) begin
      logic [63:0] a, d;
      logic [1:0]  w;
      ws = $urandom_range(0, 2);
      a  = 64'h9000 + 64'($urandom_range(0, 63));
      w  = 2'($urandom_range(0, 3));
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       do_fetch(a, "r_fetch");
        1:       do_data(a, w, d, 1'b1, 1'b0, "r_load");
        2:       do_data(a, w, d, 1'b0, 1'b1, "r_store");
        default: do_data(a, w, d, 1'b1, 1'b1, "r_both");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
